// File: rtl/layer_backward.sv
// Backward error propagation for one dense layer: err[j] = sum_i active[i]*delta[i]*w[i][j].
// One neuron per cycle, all NUM_INPUTS accumulators updated in parallel, then shift+saturate.
module layer_backward #(
  parameter int NUM_NEURON      = 6,
  parameter int NUM_INPUTS      = 5,
  parameter int DELTA_SIZE      = 10,
  parameter int WEIGHT_SIZE     = 17,
  parameter int OUTPUT_SIZE     = 10,
  parameter int DELTA_FRACTION  = 7,
  parameter int WEIGHT_FRACTION = 8,
  parameter int OUTPUT_FRACTION = 7
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic                                       start_i,
  input  logic [NUM_NEURON-1:0]                      active_i,
  input  logic [NUM_NEURON*DELTA_SIZE-1:0]           deltas_i,
  input  logic [NUM_NEURON*NUM_INPUTS*WEIGHT_SIZE-1:0] weights_i,
  output logic [NUM_INPUTS*OUTPUT_SIZE-1:0]          out_errors_o,
  output logic [NUM_INPUTS-1:0]                      out_valid_o,
  output logic                                       busy_o
);

  localparam int PROD_W = DELTA_SIZE + WEIGHT_SIZE;
  localparam int ACC_W  = PROD_W + $clog2(NUM_NEURON);
  localparam int SHIFT  = DELTA_FRACTION + WEIGHT_FRACTION - OUTPUT_FRACTION;
  localparam int CNT_W  = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_NEURON - 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX = (ACC_W'(1) <<< (OUTPUT_SIZE - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = -(ACC_W'(1) <<< (OUTPUT_SIZE - 1));

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  logic [1:0]                        state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [NUM_NEURON-1:0]             active_q, active_d;
  logic [NUM_NEURON*DELTA_SIZE-1:0]  deltas_q, deltas_d;
  logic signed [ACC_W-1:0]           acc_q [NUM_INPUTS];
  logic signed [ACC_W-1:0]           acc_d [NUM_INPUTS];
  logic [NUM_INPUTS*OUTPUT_SIZE-1:0] err_q, err_d;
  logic [NUM_INPUTS-1:0]             valid_q, valid_d;
  logic                              busy_q, busy_d;

  logic signed [DELTA_SIZE-1:0]  d_arr [NUM_NEURON];
  logic signed [WEIGHT_SIZE-1:0] w_arr [NUM_NEURON][NUM_INPUTS];
  logic signed [PROD_W-1:0]      prod  [NUM_INPUTS];
  logic [NUM_INPUTS*OUTPUT_SIZE-1:0] sat_vec;
  logic signed [DELTA_SIZE-1:0]  cur_delta;
  logic                          cur_active;

  // Unpack the flat buses with constant slices so the per-cycle select is a plain array index.
  for (genvar gn = 0; gn < NUM_NEURON; gn++) begin : g_unpack
    assign d_arr[gn] = deltas_q[gn*DELTA_SIZE +: DELTA_SIZE];
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_w
      assign w_arr[gn][gi] = weights_i[(gn*NUM_INPUTS + gi)*WEIGHT_SIZE +: WEIGHT_SIZE];
    end
  end

  assign cur_delta  = d_arr[cnt_q];
  assign cur_active = active_q[cnt_q];

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_lane
    logic signed [ACC_W-1:0] shifted;
    assign prod[gi] = PROD_W'(cur_delta) * PROD_W'(w_arr[cnt_q][gi]);
    // Arithmetic shift floors toward minus infinity before clamping.
    assign shifted  = acc_q[gi] >>> SHIFT;
    assign sat_vec[gi*OUTPUT_SIZE +: OUTPUT_SIZE] =
        (shifted > OUT_MAX) ? OUT_MAX[OUTPUT_SIZE-1:0] :
        (shifted < OUT_MIN) ? OUT_MIN[OUTPUT_SIZE-1:0] :
                              shifted[OUTPUT_SIZE-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    deltas_d = deltas_q;
    err_d    = err_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    for (int j = 0; j < NUM_INPUTS; j++) acc_d[j] = acc_q[j];

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          active_d = active_i;
          deltas_d = deltas_i;
          cnt_d    = '0;
          for (int j = 0; j < NUM_INPUTS; j++) acc_d[j] = '0;
          valid_d  = '0;
          busy_d   = 1'b1;
          state_d  = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (cur_active) begin
          for (int j = 0; j < NUM_INPUTS; j++) acc_d[j] = acc_q[j] + ACC_W'(prod[j]);
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_OUT;
      end
      ST_OUT: begin
        err_d   = sat_vec;
        valid_d = '1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      active_q <= '0;
      deltas_q <= '0;
      err_q    <= '0;
      valid_q  <= '0;
      busy_q   <= 1'b0;
      for (int j = 0; j < NUM_INPUTS; j++) acc_q[j] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      deltas_q <= deltas_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      for (int j = 0; j < NUM_INPUTS; j++) acc_q[j] <= acc_d[j];
    end
  end

  assign out_errors_o = err_q;
  assign out_valid_o  = valid_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_layer_backward.sv
// Directed bench for layer_backward: hand-computed propagated errors, latency and protocol edge cases.
module tb_layer_backward;

  localparam int NN = 6;
  localparam int NI = 5;
  localparam int DS = 10;
  localparam int WS = 17;
  localparam int OS = 10;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 start_i;
  logic [NN-1:0]        active_i;
  logic [NN*DS-1:0]     deltas_i;
  logic [NN*NI*WS-1:0]  weights_i;
  logic [NI*OS-1:0]     out_errors_o;
  logic [NI-1:0]        out_valid_o;
  logic                 busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  layer_backward dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .active_i     (active_i),
    .deltas_i     (deltas_i),
    .weights_i    (weights_i),
    .out_errors_o (out_errors_o),
    .out_valid_o  (out_valid_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_delta(input int i, input int v);
    logic [31:0] t;
    t = v;
    deltas_i[i*DS +: DS] = t[DS-1:0];
  endtask

  task automatic set_w(input int i, input int j, input int v);
    logic [31:0] t;
    t = v;
    weights_i[(i*NI + j)*WS +: WS] = t[WS-1:0];
  endtask

  task automatic fill(input int d, input int w);
    for (int i = 0; i < NN; i++) begin
      set_delta(i, d);
      for (int j = 0; j < NI; j++) set_w(i, j, w);
    end
  endtask

  function automatic logic signed [31:0] err(input int j);
    logic signed [OS-1:0] e;
    e = out_errors_o[j*OS +: OS];
    return 32'(e);
  endfunction

  task automatic check_errs(input string name, input int e0, input int e1, input int e2,
                            input int e3, input int e4);
    int exp_v [NI];
    exp_v = '{e0, e1, e2, e3, e4};
    for (int j = 0; j < NI; j++) check($sformatf("%s err[%0d]", name, j), err(j), exp_v[j]);
  endtask

  // Raise start at the current negedge so it is sampled at the next rising edge.
  task automatic start_now();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // Wait for completion from the negedge after the start edge; optionally re-pulse start
  // with scrambled inputs at cycles 2 and 6 to show they are ignored.
  task automatic wait_done(input string name, input bit inject);
    int lat;
    int busy_cnt;
    lat      = 0;
    busy_cnt = busy_o ? 1 : 0;
    check({name, " valid cleared"}, 32'(out_valid_o), 0);
    while (lat < 20) begin
      @(negedge clk_i);
      lat++;
      if (inject && (lat == 2 || lat == 6)) begin
        start_i  = 1'b1;
        active_i = '1;
        deltas_i = {NN{10'sd200}};
      end else begin
        start_i = 1'b0;
      end
      if (out_valid_o == '1) break;
      if (busy_o) busy_cnt++;
    end
    start_i = 1'b0;
    check({name, " latency"}, lat, 7);
    check({name, " busy cycles"}, busy_cnt, 7);
    check({name, " busy after done"}, 32'(busy_o), 0);
    $display("run %-12s latency=%0d busy=%0d errors=%0d,%0d,%0d,%0d,%0d", name, lat, busy_cnt,
             err(0), err(1), err(2), err(3), err(4));
  endtask

  task automatic run(input string name, input bit inject);
    @(negedge clk_i);
    start_now();
    wait_done(name, inject);
  endtask

  initial begin
    rst_i     = 1'b1;
    start_i   = 1'b0;
    active_i  = '0;
    deltas_i  = '0;
    weights_i = '0;
    repeat (2) @(negedge clk_i);
    check("reset busy", 32'(busy_o), 0);
    check("reset valid", 32'(out_valid_o), 0);
    check("reset errors", 32'(out_errors_o == '0), 1);
    rst_i = 1'b0;
    @(negedge clk_i);

    fill(0, 256); set_delta(0, 128); active_i = 6'b000001;
    run("single", 1'b0);
    check("single valid", 32'(out_valid_o), 5'b11111);
    check_errs("single", 128, 128, 128, 128, 128);

    fill(128, 256); active_i = 6'b000011;
    run("mask2", 1'b0);
    check_errs("mask2", 256, 256, 256, 256, 256);

    active_i = 6'b111111;
    run("possat", 1'b0);
    check_errs("possat", 511, 511, 511, 511, 511);

    fill(0, 256); set_delta(0, -64); active_i = 6'b000001;
    run("neg", 1'b0);
    check_errs("neg", -64, -64, -64, -64, -64);

    fill(0, 1); set_delta(0, -1);
    run("floor", 1'b0);
    check_errs("floor", -1, -1, -1, -1, -1);

    fill(-512, 256); active_i = 6'b111111;
    run("negsat", 1'b0);
    check_errs("negsat", -512, -512, -512, -512, -512);

    fill(0, 0); set_delta(0, 128); set_delta(1, -128);
    for (int j = 0; j < NI; j++) begin
      set_w(0, j, 256 * (j + 1));
      set_w(1, j, 256);
    end
    active_i = 6'b000011;
    run("mixed", 1'b0);
    check_errs("mixed", 0, 128, 256, 384, 511);

    // Extra starts at cycle 2 (busy) and cycle 6 (OUT edge) must not disturb the run.
    fill(128, 256); active_i = 6'b000011;
    run("protocol", 1'b1);
    check_errs("protocol", 256, 256, 256, 256, 256);
    @(negedge clk_i);
    check("protocol no restart", 32'(busy_o), 0);
    check("protocol valid held", 32'(out_valid_o), 5'b11111);

    active_i = '0;
    run("inactive", 1'b0);
    check("inactive valid", 32'(out_valid_o), 5'b11111);
    check_errs("inactive", 0, 0, 0, 0, 0);

    // Back-to-back: start in the very first idle cycle after completion.
    fill(0, 256); set_delta(0, 128); active_i = 6'b000001;
    start_now();
    check("b2b busy", 32'(busy_o), 1);
    wait_done("b2b", 1'b0);
    check_errs("b2b", 128, 128, 128, 128, 128);

    // Reset abort mid-run clears everything without waiting for a clock.
    fill(128, 256); active_i = 6'b111111;
    @(negedge clk_i);
    start_now();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("abort busy", 32'(busy_o), 0);
    check("abort valid", 32'(out_valid_o), 0);
    check("abort errors", 32'(out_errors_o == '0), 1);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (9) @(negedge clk_i);
    check("abort no pulse", 32'(out_valid_o), 0);

    fill(0, 256); set_delta(0, 128); active_i = 6'b000001;
    run("fresh", 1'b0);
    check_errs("fresh", 128, 128, 128, 128, 128);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
